uart_tx_buffered: RTL and testbench

- 8N1 UART transmitter with an internal byte FIFO, for the display engine's return path to the host (status, echo, error codes).
- Producer logic pushes bytes with a valid/ready handshake; the block serialises them back-to-back on tx.
- Matches the system UART format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_buffered.sv | 130 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing constants and transmitter state type, also used by the receive path.
package uart_pkg;

    localparam int   UART_DATA_BITS      = 8;
    localparam logic START_BIT           = 1'b0;
    localparam logic STOP_BIT            = 1'b1;
    localparam logic IDLE_LEVEL          = 1'b1;
    localparam int   DEFAULT_CLK_PER_BIT = 434;
    localparam int   DEFAULT_FIFO_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and a combinational head (dout) read.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    assign do_push = push && (count < CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // Flags are registered from the next count so downstream ready is a clean flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back-to-back while bytes are queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    logic [CNT_W-1:0]          baud_cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [7:0]                fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      bit_end;
    logic                      fifo_nz_next;

    // Handshake: a byte transfers on the rising edge where data_valid && data_ready.
    assign data_ready   = !fifo_full;
    assign push         = data_valid && data_ready;
    assign bit_end      = (baud_cnt == CNT_LAST);
    assign pop          = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign fifo_nz_next = push || (fifo_count > CW'(pop));

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (data_in),
        .dout (fifo_dout),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= IDLE_LEVEL;
            busy      <= 1'b0;
        end else begin
            busy <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_dout;
                        baud_cnt  <= '0;
                        tx        <= START_BIT;
                        state     <= START;
                    end else begin
                        tx   <= IDLE_LEVEL;
                        busy <= fifo_nz_next;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            tx    <= STOP_BIT;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        // A queued byte starts its frame on the very next cycle, no idle gap.
                        if (pop) begin
                            shift_reg <= fifo_dout;
                            tx        <= START_BIT;
                            state     <= START;
                        end else begin
                            tx    <= IDLE_LEVEL;
                            state <= IDLE;
                            busy  <= fifo_nz_next;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: hand frame tables, corner sequences, and random traffic against a line-level model.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int   n_vec = 0;
    int   n_err = 0;
    logic chk_en = 1'b0;

    uart_tx_buffered #(
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued bytes plus the exact line level for every upcoming cycle.
    logic [7:0] m_fifo[$];
    logic       m_line[$];
    logic       m_ready = 1'b1;
    logic [7:0] acc_q[$];
    logic [7:0] rx_q[$];

    always @(posedge clk) begin : model_step
        logic       take;
        logic       start;
        logic [7:0] b;
        if (!reset) begin
            take  = data_valid && m_ready;
            start = (m_line.size() <= 1) && (m_fifo.size() > 0);
            if (m_line.size() > 0) m_line.delete(0);
            if (start) begin
                b = m_fifo.pop_front();
                for (int k = 0; k < 10; k++)
                    for (int c = 0; c < CPB; c++)
                        m_line.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : b[k-1]));
            end
            if (take) begin
                m_fifo.push_back(data_in);
                acc_q.push_back(data_in);
            end
            m_ready = (m_fifo.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("tx", tx, m_line.size() > 0 ? m_line[0] : 1'b1);
            chk("busy", busy, (m_line.size() > 0) || (m_fifo.size() > 0));
            chk("data_ready", data_ready, m_ready);
            chk("fifo_count", fifo_count, m_fifo.size());
        end
    end

    // Golden line decoder: samples each bit mid-period and collects received bytes.
    logic       dec_busy = 1'b0;
    int         dec_cyc = 0;
    logic [7:0] dec_sh = 8'h00;

    always @(negedge clk) begin : decoder
        int k;
        if (reset) begin
            dec_busy = 1'b0;
        end else if (chk_en) begin
            if (!dec_busy) begin
                if (tx == 1'b0) begin
                    dec_busy = 1'b1;
                    dec_cyc  = 0;
                end
            end else begin
                dec_cyc++;
                if (dec_cyc % CPB == CPB / 2) begin
                    k = dec_cyc / CPB;
                    if (k >= 1 && k <= 8) dec_sh[k-1] = tx;
                    else if (k == 9) begin
                        chk("dec_stop_bit", tx, 1'b1);
                        rx_q.push_back(dec_sh);
                    end
                end
                if (dec_cyc == FRAME - 1) dec_busy = 1'b0;
            end
        end
    end

    int   max_cnt = 0;
    logic saw_nr = 1'b0;

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stream(input string name);
        chk({name, "_len"}, rx_q.size(), acc_q.size());
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) chk(name, rx_q[i], acc_q[i]);
        rx_q.delete();
        acc_q.delete();
    endtask

    task automatic push_hold(input logic [7:0] b);
        logic acc;
        int   k;
        data_valid = 1'b1;
        data_in    = b;
        acc        = 1'b0;
        k          = 0;
        while (!acc && k < 200) begin
            @(negedge clk);
            acc = data_ready;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (!data_ready) saw_nr = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        chk("push_timeout", acc, 1'b1);
    endtask

    task automatic assert_reset();
        #2;
        reset      = 1'b1;
        data_valid = 1'b0;
        m_fifo.delete();
        m_line.delete();
        m_ready = 1'b1;
        acc_q.delete();
        rx_q.delete();
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", data_ready, 1'b1);
        chk("rst_count", fifo_count, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [0:9] f0;
        logic [0:9] f1;
    } vec_t;

    vec_t tbl[5];

    task automatic run_vec(input vec_t v);
        logic exp_bit;
        wait_idle(2000);
        data_valid = 1'b1;
        data_in    = v.b0;
        @(posedge clk);
        #1;
        if (v.n == 2) data_in = v.b1;
        else data_valid = 1'b0;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        for (int c = 0; c < v.n * FRAME; c++) begin
            @(negedge clk);
            exp_bit = (c < FRAME) ? v.f0[c / CPB] : v.f1[(c - FRAME) / CPB];
            chk("tbl_tx", tx, exp_bit);
            chk("tbl_busy", busy, 1'b1);
            chk("tbl_ready", data_ready, 1'b1);
        end
        @(negedge clk);
        chk("tbl_busy_end", busy, 1'b0);
        chk("tbl_tx_end", tx, 1'b1);
    endtask

    initial begin
        tbl[0] = '{1, 8'h55, 8'h00, 10'b0101010101, 10'b0000000000};
        tbl[1] = '{2, 8'h01, 8'hFE, 10'b0100000001, 10'b0011111111};
        tbl[2] = '{1, 8'hA3, 8'h00, 10'b0110001011, 10'b0000000000};
        tbl[3] = '{2, 8'h00, 8'hFF, 10'b0000000001, 10'b0111111111};
        tbl[4] = '{1, 8'hC4, 8'h00, 10'b0001000111, 10'b0000000000};

        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", data_ready, 1'b1);
        chk("reset_count", fifo_count, 0);
        chk_en = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);
        wait_idle(2000);
        chk_stream("tbl_stream");

        // Back-pressure: 12 distinct bytes with valid held high.
        max_cnt = 0;
        saw_nr  = 1'b0;
        for (int i = 0; i < 12; i++) push_hold(8'(8'h10 + i * 13));
        data_valid = 1'b0;
        chk("bp_max_count", max_cnt, DEPTH);
        chk("bp_saw_not_ready", saw_nr, 1'b1);
        wait_idle(2000);
        chk_stream("bp_stream");

        // Push lands on the edge that ends a stop bit while three bytes are queued.
        data_valid = 1'b1;
        data_in    = 8'h31;
        @(posedge clk); #1; data_in = 8'h32;
        @(posedge clk); #1; data_in = 8'h33;
        @(posedge clk); #1; data_in = 8'h34;
        @(posedge clk); #1; data_valid = 1'b0;
        repeat (FRAME - 3) @(posedge clk);
        #1;
        data_valid = 1'b1;
        data_in    = 8'h35;
        @(negedge clk);
        chk("pp_count_before", fifo_count, 3);
        chk("pp_tx_stop", tx, 1'b1);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        @(negedge clk);
        chk("pp_count_after", fifo_count, 3);
        chk("pp_tx_start", tx, 1'b0);
        chk("pp_busy", busy, 1'b1);
        wait_idle(2000);
        chk_stream("pp_stream");

        // Reset during data bit 4 with two bytes queued.
        data_valid = 1'b1;
        data_in    = 8'h41;
        @(posedge clk); #1; data_in = 8'h42;
        @(posedge clk); #1; data_in = 8'h43;
        @(posedge clk); #1; data_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_count", fifo_count, 2);
        chk("mid_tx_bit4", tx, 1'b0);
        assert_reset();
        run_vec(tbl[2]);
        wait_idle(2000);
        chk_stream("rst_stream");

        // Full FIFO ignores offered 0xFF.
        for (int i = 0; i < 9; i++) push_hold(8'(8'h60 + i));
        data_in = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("full_count", fifo_count, DEPTH);
            chk("full_ready", data_ready, 1'b0);
        end
        data_valid = 1'b0;
        wait_idle(2000);
        chk_stream("full_stream");

        // Random traffic alternating sparse and dense offer rates.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ((i % 400) < 200) data_valid = ($urandom_range(0, 9) == 0);
            else data_valid = ($urandom_range(0, 1) == 1);
            data_in = 8'($urandom);
        end
        data_valid = 1'b0;
        wait_idle(4000);
        chk_stream("rand_stream");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
